// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM pipeline stage (master) and the data memory (slave).
interface mem_stage_if;
  localparam int unsigned XLEN = 32;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory transfers, stalls upstream until ack, feeds MEM/WB.
// Optional feature: define MEM_TIMEOUT_EN to abandon a transfer after 255 un-acked ACCESS cycles.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic [31:0] PCIn,
  input  logic [31:0] ALUResIn,
  input  logic [31:0] STValIn,
  input  logic [4:0]  destIn,
  mem_stage_if.master mem,
  output logic        freeze,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic [4:0]  dest,
  output logic [31:0] PC,
  output logic [31:0] ALURes,
  output logic [31:0] MemRes,
  output logic        timeout_err
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t          state;
  logic            pending_c;
  logic            advance_c;
  logic            wb_en_c;
  logic [XLEN-1:0] mem_res_c;
  logic            timeout_hit_c;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned    TO_W     = 8;
  localparam logic [TO_W-1:0] TO_LIMIT = '1;

  logic [TO_W-1:0] to_cnt;

  assign timeout_hit_c = (state == ACCESS) && !mem.mem_ack && (to_cnt == TO_LIMIT);

  // Counts un-acked ACCESS cycles; held at zero outside ACCESS so each entry starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != ACCESS) begin
      to_cnt <= '0;
    end else if (!mem.mem_ack) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit_c) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit_c = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  // Decide whether the MEM/WB register takes the current op or a bubble this cycle.
  always_comb begin
    pending_c = MEM_R_EN_IN | MEM_W_EN_IN;
    advance_c = 1'b0;
    wb_en_c   = WB_EN_IN;
    mem_res_c = '0;
    case (state)
      IDLE: begin
        advance_c = !pending_c;
      end
      ACCESS: begin
        if (mem.mem_ack) begin
          advance_c = 1'b1;
          if (MEM_R_EN_IN) begin
            mem_res_c = mem.mem_rdata;
          end
        end else if (timeout_hit_c) begin
          advance_c = 1'b1;
          wb_en_c   = 1'b0;
        end
      end
      default: begin
        advance_c = 1'b0;
      end
    endcase
  end

  assign freeze = !rst && !advance_c;

  // A read wins over a simultaneous write, so the write strobe is masked by the read bit.
  assign mem.mem_req   = (state == ACCESS);
  assign mem.mem_we    = (state == ACCESS) && MEM_W_EN_IN && !MEM_R_EN_IN;
  assign mem.mem_addr  = {ALUResIn[XLEN-1:2], 2'b00};
  assign mem.mem_wdata = STValIn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      WB_EN    <= 1'b0;
      MEM_R_EN <= 1'b0;
      dest     <= '0;
      PC       <= '0;
      ALURes   <= '0;
      MemRes   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending_c) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (advance_c) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (advance_c) begin
        WB_EN    <= wb_en_c;
        MEM_R_EN <= MEM_R_EN_IN;
        dest     <= destIn;
        PC       <= PCIn;
        ALURes   <= ALUResIn;
        MemRes   <= mem_res_c;
      end else begin
        WB_EN    <= 1'b0;
        MEM_R_EN <= 1'b0;
        dest     <= REG_W'(0);
        PC       <= XLEN'(0);
        ALURes   <= XLEN'(0);
        MemRes   <= XLEN'(0);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, corner sequences and randomized ops vs a model.
`timescale 1ns/1ps
module tb_mem_stage;

  localparam int unsigned MAX_CYC = 1000;

  typedef struct {
    logic        wb;
    logic        rd;
    logic        wr;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] st;
    logic [4:0]  dst;
    logic [31:0] rdata;
    int unsigned delay;
    logic [31:0] e_addr;
    logic        e_we;
    logic        e_wb;
    logic        e_ren;
    logic [31:0] e_memres;
    int unsigned e_frz;
    int unsigned e_req;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
  logic [31:0] PCIn, ALUResIn, STValIn;
  logic [4:0]  destIn;
  logic        freeze;
  logic        WB_EN, MEM_R_EN;
  logic [4:0]  dest;
  logic [31:0] PC, ALURes, MemRes;
  logic        timeout_err;

  int unsigned n_checks;
  int unsigned n_fail;

  mem_stage_if mem_bus();

  mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .WB_EN_IN    (WB_EN_IN),
    .MEM_R_EN_IN (MEM_R_EN_IN),
    .MEM_W_EN_IN (MEM_W_EN_IN),
    .PCIn        (PCIn),
    .ALUResIn    (ALUResIn),
    .STValIn     (STValIn),
    .destIn      (destIn),
    .mem         (mem_bus),
    .freeze      (freeze),
    .WB_EN       (WB_EN),
    .MEM_R_EN    (MEM_R_EN),
    .dest        (dest),
    .PC          (PC),
    .ALURes      (ALURes),
    .MemRes      (MemRes),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: what an op should look like from outside, derived from the stage's rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic is_mem = v.rd | v.wr;
    r.e_addr   = v.alu & 32'hFFFF_FFFC;
    r.e_we     = v.wr & ~v.rd;
    r.e_wb     = v.wb;
    r.e_ren    = v.rd;
    r.e_memres = (is_mem && v.rd) ? v.rdata : 32'h0;
    r.e_frz    = is_mem ? v.delay + 1 : 0;
    r.e_req    = is_mem ? v.delay + 1 : 0;
    return r;
  endfunction

  function automatic vec_t mk(input logic wb, input logic rd, input logic wr,
                              input logic [31:0] pc, input logic [31:0] alu,
                              input logic [31:0] st, input logic [4:0] dst,
                              input logic [31:0] rdata, input int unsigned delay);
    vec_t v;
    v.wb = wb; v.rd = rd; v.wr = wr; v.pc = pc; v.alu = alu; v.st = st;
    v.dst = dst; v.rdata = rdata; v.delay = delay;
    v.e_addr = '0; v.e_we = 1'b0; v.e_wb = 1'b0; v.e_ren = 1'b0;
    v.e_memres = '0; v.e_frz = 0; v.e_req = 0;
    return v;
  endfunction

  // Entered and left at posedge+1; acks after v.delay un-acked ACCESS cycles.
  task automatic run_op(input vec_t v, input string tag);
    int unsigned frz_n = 0;
    int unsigned req_n = 0;
    logic prev_frz = 1'b0;
    logic done = 1'b0;
    WB_EN_IN = v.wb; MEM_R_EN_IN = v.rd; MEM_W_EN_IN = v.wr;
    PCIn = v.pc; ALUResIn = v.alu; STValIn = v.st; destIn = v.dst;
    for (int c = 0; c < int'(MAX_CYC) && !done; c++) begin
      mem_bus.mem_ack = 1'b0;
      mem_bus.mem_rdata = $urandom();
      if (mem_bus.mem_req) begin
        req_n++;
        if (req_n > v.delay) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = v.rdata;
        end
      end
      @(negedge clk);
      if (prev_frz) begin
        chk({tag, ".bub_wb"}, 32'(WB_EN), 32'h0);
        chk({tag, ".bub_ren"}, 32'(MEM_R_EN), 32'h0);
      end
      if (mem_bus.mem_req) begin
        chk({tag, ".addr"}, mem_bus.mem_addr, v.e_addr);
        chk({tag, ".we"}, 32'(mem_bus.mem_we), 32'(v.e_we));
        chk({tag, ".wdata"}, mem_bus.mem_wdata, v.st);
      end
      if (freeze) frz_n++;
      prev_frz = freeze;
      done = !freeze;
      @(posedge clk); #1;
    end
    mem_bus.mem_ack = 1'b0;
    chk({tag, ".retired"}, 32'(done), 32'h1);
    chk({tag, ".frz_cyc"}, frz_n, v.e_frz);
    chk({tag, ".req_cyc"}, req_n, v.e_req);
    chk({tag, ".WB_EN"}, 32'(WB_EN), 32'(v.e_wb));
    chk({tag, ".MEM_R_EN"}, 32'(MEM_R_EN), 32'(v.e_ren));
    chk({tag, ".dest"}, 32'(dest), 32'(v.dst));
    chk({tag, ".PC"}, PC, v.pc);
    chk({tag, ".ALURes"}, ALURes, v.alu);
    chk({tag, ".MemRes"}, MemRes, v.e_memres);
  endtask

  vec_t tbl[6];
  vec_t v;

  initial begin
    #100000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    WB_EN_IN = 1'b1; MEM_R_EN_IN = 1'b1; MEM_W_EN_IN = 1'b0;
    PCIn = 32'h55; ALUResIn = 32'h66; STValIn = 32'h77; destIn = 5'd9;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;

    // Reset state, with a pending load that must not raise freeze.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.freeze", 32'(freeze), 32'h0);
    chk("rst.mem_req", 32'(mem_bus.mem_req), 32'h0);
    chk("rst.WB_EN", 32'(WB_EN), 32'h0);
    chk("rst.MEM_R_EN", 32'(MEM_R_EN), 32'h0);
    chk("rst.dest", 32'(dest), 32'h0);
    chk("rst.PC", PC, 32'h0);
    chk("rst.ALURes", ALURes, 32'h0);
    chk("rst.MemRes", MemRes, 32'h0);
    chk("rst.timeout_err", 32'(timeout_err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table with hand-derived expectations.
    tbl[0] = mk(1, 0, 0, 32'h100, 32'h25, 32'h0, 5'd3, 32'h0, 0);
    tbl[0].e_wb = 1; tbl[0].e_memres = 32'h0; tbl[0].e_frz = 0; tbl[0].e_req = 0;
    tbl[1] = mk(1, 1, 0, 32'h104, 32'h407, 32'h0, 5'd5, 32'hDEAD_BEEF, 0);
    tbl[1].e_addr = 32'h404; tbl[1].e_wb = 1; tbl[1].e_ren = 1;
    tbl[1].e_memres = 32'hDEAD_BEEF; tbl[1].e_frz = 1; tbl[1].e_req = 1;
    tbl[2] = mk(0, 0, 1, 32'h108, 32'h2000, 32'h1234, 5'd0, 32'hCAFE_F00D, 2);
    tbl[2].e_addr = 32'h2000; tbl[2].e_we = 1; tbl[2].e_frz = 3; tbl[2].e_req = 3;
    tbl[3] = mk(1, 1, 1, 32'h10C, 32'h3003, 32'h5555, 5'd7, 32'h0BAD_F00D, 1);
    tbl[3].e_addr = 32'h3000; tbl[3].e_wb = 1; tbl[3].e_ren = 1;
    tbl[3].e_memres = 32'h0BAD_F00D; tbl[3].e_frz = 2; tbl[3].e_req = 2;
    tbl[4] = mk(0, 0, 0, 32'h110, 32'hFFFF_FFFF, 32'h0, 5'd31, 32'h0, 0);
    tbl[5] = mk(1, 1, 0, 32'h114, 32'hFFFF_FFFE, 32'h0, 5'd1, 32'h8000_0001, 4);
    tbl[5].e_addr = 32'hFFFF_FFFC; tbl[5].e_wb = 1; tbl[5].e_ren = 1;
    tbl[5].e_memres = 32'h8000_0001; tbl[5].e_frz = 5; tbl[5].e_req = 5;
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i], $sformatf("tbl%0d", i));
    end

    // An ack while IDLE must be ignored.
    WB_EN_IN = 1'b1; MEM_R_EN_IN = 1'b0; MEM_W_EN_IN = 1'b0;
    PCIn = 32'h180; ALUResIn = 32'h42; destIn = 5'd2;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("idle_ack.freeze", 32'(freeze), 32'h0);
    chk("idle_ack.mem_req", 32'(mem_bus.mem_req), 32'h0);
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b0;
    chk("idle_ack.MemRes", MemRes, 32'h0);
    chk("idle_ack.WB_EN", 32'(WB_EN), 32'h1);
    chk("idle_ack.mem_req2", 32'(mem_bus.mem_req), 32'h0);

    // Reset while in ACCESS, then a late ack alongside an ALU op.
    WB_EN_IN = 1'b1; MEM_R_EN_IN = 1'b1; PCIn = 32'h1C0; ALUResIn = 32'h40; destIn = 5'd6;
    @(posedge clk); #1;
    chk("rst_acc.in_access", 32'(mem_bus.mem_req), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_acc.freeze", 32'(freeze), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_acc.WB_EN", 32'(WB_EN), 32'h0);
    chk("rst_acc.ALURes", ALURes, 32'h0);
    WB_EN_IN = 1'b1; MEM_R_EN_IN = 1'b0; MEM_W_EN_IN = 1'b0;
    PCIn = 32'h200; ALUResIn = 32'h99; destIn = 5'd9;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("rst_acc.mem_req", 32'(mem_bus.mem_req), 32'h0);
    chk("rst_acc.freeze2", 32'(freeze), 32'h0);
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b0;
    chk("rst_acc.alu_WB_EN", 32'(WB_EN), 32'h1);
    chk("rst_acc.alu_ALURes", ALURes, 32'h99);
    chk("rst_acc.alu_dest", 32'(dest), 32'h9);
    chk("rst_acc.alu_MemRes", MemRes, 32'h0);
    chk("rst_acc.alu_MEM_R_EN", 32'(MEM_R_EN), 32'h0);

    // Randomized ops against the model.
    for (int i = 0; i < 40; i++) begin
      v = mk(1'($urandom()), 1'($urandom()), 1'($urandom()), $urandom(), $urandom(),
             $urandom(), 5'($urandom()), $urandom(), $urandom_range(0, 4));
      v = model(v);
      run_op(v, $sformatf("rnd%0d", i));
    end

`ifdef MEM_TIMEOUT_EN
    // Load that is never acked: released after 255 waiting ACCESS cycles.
    v = mk(1, 1, 0, 32'h300, 32'h501, 32'h0, 5'd4, 32'h0, 100000);
    v.e_addr = 32'h500; v.e_wb = 0; v.e_ren = 1; v.e_memres = 32'h0;
    v.e_frz = 256; v.e_req = 256;
    run_op(v, "tmo");
    chk("tmo.err_set", 32'(timeout_err), 32'h1);
    v = mk(1, 0, 0, 32'h304, 32'h11, 32'h0, 5'd8, 32'h0, 0);
    v = model(v);
    run_op(v, "tmo_alu");
    chk("tmo.err_sticky", 32'(timeout_err), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("tmo.err_clr", 32'(timeout_err), 32'h0);
`else
    // Long wait: no timeout exists, the stage just keeps stalling.
    v = mk(1, 1, 0, 32'h300, 32'h501, 32'h0, 5'd4, 32'hA5A5_0F0F, 300);
    v = model(v);
    run_op(v, "long");
    chk("long.timeout_err", 32'(timeout_err), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; clk and rst are listed first.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN  in  1 each  control bits from the EXE/MEM pipeline register.
REQ-005 PCIn, ALUResIn, STValIn  in  32 each  PC, ALU result (byte address for loads/stores), store data.
REQ-006 destIn  in  5  destination register index.
REQ-007 mem_req  out  1  data-memory request; mem_we  out  1  write strobe.
REQ-008 mem_addr  out  32  word-aligned address; mem_wdata  out  32  store data.
REQ-009 mem_rdata  in  32  read data, valid with mem_ack; mem_ack  in  1  transfer complete.
REQ-010 freeze  out  1  stall request to PC, IF/ID, ID/EXE and EXE/MEM registers.
REQ-011 WB_EN, MEM_R_EN  out  1 each; dest  out  5; PC, ALURes, MemRes  out  32 each; registered MEM/WB outputs.
REQ-012 timeout_err  out  1  sticky memory-timeout flag.

Function
REQ-013 FSM states SHALL be IDLE and ACCESS only.
REQ-014 Access pending = MEM_R_EN_IN | MEM_W_EN_IN; both set SHALL be treated as a read, with the write suppressed.
REQ-015 IDLE, no access pending: freeze=0; MEM/WB outputs load inputs at the next edge (1-cycle latency); MemRes loads 0.
REQ-016 IDLE, access pending: freeze=1 combinationally; MEM/WB outputs load a bubble (all control bits 0); next state ACCESS.
REQ-017 ACCESS: mem_req=1 (decoded from state); mem_we = MEM_W_EN_IN & ~MEM_R_EN_IN; mem_addr = {ALUResIn[31:2],2'b00}; mem_wdata = STValIn.
REQ-018 Outside ACCESS, mem_req and mem_we SHALL be 0; mem_addr and mem_wdata are don't-care.
REQ-019 ACCESS, mem_ack=0: freeze=1; outputs load a bubble; stay in ACCESS.
REQ-020 ACCESS, mem_ack=1: freeze=0 in the same cycle; at the edge, outputs load the inputs, MemRes loads mem_rdata for a read or 0 for a write, and state goes to IDLE.
REQ-021 Minimum access latency SHALL be 2 cycles: detect in IDLE, ack in the first ACCESS cycle.
REQ-022 Upstream SHALL hold all *_IN inputs stable while freeze=1; the block does not latch them.
REQ-023 mem_ack in IDLE SHALL be ignored.
REQ-024 Back-to-back memory ops: each op SHALL re-enter ACCESS through IDLE, so there is one bubble minimum per memory op.
REQ-025 MEM_R_EN output SHALL mirror the accepted op's read bit for the writeback mux.

Reset
REQ-026 On rst, at the clock edge: state=IDLE; WB_EN, MEM_R_EN, dest, PC, ALURes and MemRes = 0; timeout_err=0; timeout counter=0.
REQ-027 rst asserted in ACCESS SHALL abort the transfer; mem_req is 0 from the following cycle; a late mem_ack is ignored.
REQ-028 During rst, freeze SHALL be 0.

Configuration
REQ-029 Macro MEM_TIMEOUT_EN: when defined, an 8-bit counter clears on entering ACCESS and increments each ACCESS cycle without ack.
REQ-030 With MEM_TIMEOUT_EN: if the count reaches 255 without ack, then freeze=0 that cycle, outputs load the inputs with WB_EN forced to 0, state goes to IDLE, and timeout_err is set until rst.
REQ-031 Without MEM_TIMEOUT_EN: ACCESS waits indefinitely, no counter exists, and timeout_err is tied to 0.

Verification
REQ-032 ALU op: WB_EN_IN=1, R/W=0, ALUResIn=0x25, destIn=3 -> next cycle WB_EN=1, ALURes=0x25, dest=3, MemRes=0, freeze never 1.
REQ-033 Load with immediate ack: MEM_R_EN_IN=1, ALUResIn=0x407 -> freeze=1 for one cycle; mem_addr=0x404; ack with rdata=0xDEADBEEF -> MemRes=0xDEADBEEF, MEM_R_EN=1.
REQ-034 Store, ack after 3 ACCESS cycles: STValIn=0x1234 -> mem_we=1, mem_wdata=0x1234 for 3 cycles; freeze=1 for 3 cycles; bubbles on outputs; then WB_EN=0 and store retired.
REQ-035 rst during ACCESS, with ack on the next cycle -> mem_req=0, all outputs 0, ack ignored, and the next ALU op passes normally.
REQ-036 MEM_TIMEOUT_EN defined, load, mem_ack held 0 -> freeze released after 255 ACCESS cycles, WB_EN=0, timeout_err=1 until rst.
